tx_gearbox: RTL
===============

# tx_gearbox

Transmit-side 64b/66b gearbox for the 10GBASE-R PCS. It accepts 66-bit blocks from the encoder/scrambler as a 2-bit sync header plus two 32-bit halves. It repacks them into a continuous 32-bit stream for the PMA/SERDES, so the receive block-sync and lock logic can find a header every 66 bits. The upstream is paused for 2 cycles of every 66 to absorb the 2-bit header overhead.

## Interface
- DATA_WIDTH, 32, input/output word width; only 32 is supported.
- HDR_WIDTH, 2, sync header width.
- i_clk  input  1  PCS transmit clock.
- i_reset_n  input  1  synchronous, active-low reset.
- i_data  input  DATA_WIDTH  half-block payload, LSB first on the line.
- i_hdr  input  HDR_WIDTH  sync header; sampled only when i_hdr_valid is high.
- i_hdr_valid  input  1  marks the first half of a block.
- i_valid  input  1  i_data/i_hdr present.
- i_err_inject  input  1  header corruption request (see Configuration).
- o_ready  output  1  gearbox accepts input this cycle.
- o_data  output  DATA_WIDTH  line word, bit 0 transmitted first.
- o_data_valid  output  1  o_data holds a new word.
- o_phase_err  output  1  one-cycle pulse: i_hdr_valid disagreed with the expected block phase.

## Operation
- Sequence counter seq, 7 bits, range 0..65, wraps 65 -> 0.
- o_ready = 1 for seq 0..63 and 0 for seq 64, 65. It is decoded from the seq register only (no combinational path from inputs).
- Advance condition: (o_ready & i_valid) | !o_ready. On advance, seq increments and one 32-bit word is emitted. Otherwise everything holds and o_data_valid = 0.
- Accept at even seq (header phase):
  - Append {i_data, hdr} to the bit buffer, 34 bits; hdr occupies the lowest bits and goes out first.
  - Expected i_hdr_valid = 1.
- Accept at odd seq: append i_data, 32 bits. Expected i_hdr_valid = 0.
- Phase mismatch:
  - o_phase_err pulses on the following cycle.
  - The word is still consumed per seq parity, not per i_hdr_valid. The gearbox never re-aligns on its own.
- Bit buffer: 96 bits plus a 7-bit occupancy count.
  - Each advance emits buffer[31:0], shifts the buffer right by 32, and appends new bits at the occupancy point.
  - Residual after block j (j = 1..32) is 2j bits.
  - Peak occupancy is 96 bits, reached at seq 62 accept.
  - seq 64 and 65 drain the final 64 residual bits, leaving occupancy 0 at seq 0.
- i_valid while o_ready = 0: input ignored, no error flagged.

## Timing
- Reset values: seq = 0, buffer = 0, occupancy = 0, o_data = 0, o_data_valid = 0, o_phase_err = 0, o_ready = 1.
- Latency: the word accepted in cycle N contributes to o_data in cycle N+1. o_data and o_data_valid are registered.
- First header after reset appears at o_data[1:0] in the cycle after the first accept.
- Continuous i_valid gives an output pattern of 66 valid words per 66 cycles, with o_ready low in cycles 64 and 65 of each frame.
- An input stall (i_valid = 0 with o_ready = 1) freezes seq and the buffer. o_data holds its last value and o_data_valid = 0.
- Reset asserted mid-frame returns all state to reset values on the next edge. Partial buffered bits are discarded.

## Configuration
- Macro TX_GB_ERR_INJECT_EN.
- Defined: on a header-phase accept with i_err_inject = 1, the header is replaced by 2'b00 before packing. This exercises the receiver's invalid-header counting and slip.
- Undefined: i_err_inject is ignored and headers pass unchanged. The port remains for a stable interface.

## Test plan
- Reset, then continuous i_valid with blocks hdr=2'b01 and data=32'hA5A5_A5A5/32'h5A5A_5A5A:
  - o_ready low exactly at cycles 64 and 65.
  - Reassembled line stream has 2'b01 at every 66-bit boundary.
  - 66 valid words per frame.
- Random 32-block frame: deserialize o_data at 66-bit boundaries -> bit-exact match to input blocks. Buffer never exceeds 96 bits.
- i_valid deasserted for 5 cycles at seq 30 -> o_data_valid = 0 for those 5 cycles, seq frozen, stream resumes with no lost or duplicated bits.
- i_hdr_valid = 1 presented at an odd seq -> o_phase_err pulses once the next cycle. Data is packed as payload.
- With TX_GB_ERR_INJECT_EN, i_err_inject high for 16 consecutive blocks -> 16 headers of 2'b00 on the line, all others unchanged. Without the macro, headers are unchanged.
- Reset asserted at seq 63 with 64 residual bits buffered -> outputs return to reset values next cycle. The first post-reset word starts with a fresh header.

Source files
------------

// File: rtl/tx_gearbox.sv
// tx_gearbox: transmit-side 64b/66b gearbox for a 10GBASE-R PCS.
// Accepts 66-bit blocks as {header, low half} then {high half} and repacks
// them into a continuous 32-bit line stream. A 66-entry sequence counter
// pauses the upstream for 2 cycles per frame to absorb header overhead.
// Optional feature macro: TX_GB_ERR_INJECT_EN (header corruption on request).
//
// Handshake: a word is consumed on a clock edge where o_ready & i_valid are
// both high. o_ready depends only on the sequence register. When o_ready is
// low the gearbox advances on its own to drain its buffer, and any input is
// ignored. o_data_valid marks each cycle that carries a freshly emitted word.
module tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic                  i_hdr_valid,
  input  logic                  i_valid,
  input  logic                  i_err_inject,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_phase_err
);

  localparam int BUF_W = 96;
  localparam int BLK_W = DATA_WIDTH + HDR_WIDTH;
  localparam logic [6:0] SEQ_LAST = 7'd65;

  logic [6:0]            seq_q;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [6:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dv_q;
  logic                  perr_q;

  logic                  hdr_phase;
  logic                  accept;
  logic                  advance;
  logic [HDR_WIDTH-1:0]  hdr_eff;
  logic [BLK_W-1:0]      new_bits;
  logic [6:0]            new_len;
  logic [BUF_W-1:0]      merged;

  // Seq 64 and 65 are the drain slots; ready is decoded from the register only.
  assign o_ready   = (seq_q < 7'd64);
  assign hdr_phase = ~seq_q[0];
  assign accept    = o_ready & i_valid;
  assign advance   = accept | ~o_ready;

`ifdef TX_GB_ERR_INJECT_EN
  assign hdr_eff = (i_err_inject && hdr_phase) ? '0 : i_hdr;
`else
  // The port stays for interface stability but has no effect in this build.
  logic unused_err_inject;
  assign unused_err_inject = i_err_inject;
  assign hdr_eff = i_hdr;
`endif

  // Merge incoming bits at the occupancy point, emit the low word, keep the rest.
  always_comb begin
    new_bits = '0;
    new_len  = 7'd0;
    if (accept) begin
      if (hdr_phase) begin
        new_bits = {i_data, hdr_eff};
        new_len  = 7'(BLK_W);
      end else begin
        new_bits = {{HDR_WIDTH{1'b0}}, i_data};
        new_len  = 7'(DATA_WIDTH);
      end
    end
    merged = buf_q | ({{(BUF_W-BLK_W){1'b0}}, new_bits} << occ_q);
    data_d = merged[DATA_WIDTH-1:0];
    buf_d  = merged >> DATA_WIDTH;
    occ_d  = occ_q + new_len - 7'(DATA_WIDTH);
  end

  // Sequence, buffer and registered outputs; stalls freeze everything but flags.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      seq_q  <= '0;
      buf_q  <= '0;
      occ_q  <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      dv_q   <= advance;
      perr_q <= accept & (i_hdr_valid != hdr_phase);
      if (advance) begin
        seq_q  <= (seq_q == SEQ_LAST) ? 7'd0 : seq_q + 7'd1;
        buf_q  <= buf_d;
        occ_q  <= occ_d;
        data_q <= data_d;
      end
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = dv_q;
  assign o_phase_err  = perr_q;

endmodule
